// File: rtl/hazard_control_unit.sv
// Hazard sequencer for the 5-stage KGP-RISC pipeline: load-use stalls, taken-branch
// flushes and multi-cycle EX holds (the latter only when MULTICYCLE_STALL_EN is defined).
module hazard_control_unit #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // state   | meaning
    // RUN     | normal flow; load-use stalls and branch flushes decoded here
    // MC_BUSY | multi-cycle op still occupying EX; front of pipe held, cnt counts down

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu;

    assign lu = id_ex_memread && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == id_rs) || (id_uses_rt && (id_ex_rd == id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef MULTICYCLE_STALL_EN
    // Start cycle counts as hold cycle 1, so the counter covers the remaining MC_LATENCY-2.
    localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 2);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (!ex_branch_taken && ex_mc_start) begin
                    cnt_nxt = MC_LOAD;
                    if (MC_LATENCY == 2) state_nxt = RUN;
                    else                 state_nxt = MC_BUSY;
                end
            end
            MC_BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end
`else
    logic unused_sig;
    assign unused_sig = ^{ex_mc_start, cnt, state, 4'(MC_LATENCY)};

    always_comb begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
    end
`endif

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_busy      = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
`ifdef MULTICYCLE_STALL_EN
        end else if ((state == MC_BUSY) || (!ex_branch_taken && ex_mc_start)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            mc_busy      = 1'b1;
`endif
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
